// File: rtl/regfile_wb_arbiter.sv
// Register-file write-back arbiter: shares one write port between NUM_REQ
// valid/ready requesters using a registered round-robin pointer. Accepted
// writes reach the port one cycle later, and writes to x0 are dropped.
module regfile_wb_arbiter #(
   parameter int unsigned NUM_REQ = 3,
   parameter int unsigned ADDR_W  = 4,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned CNT_W   = 16
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic [NUM_REQ-1:0]        req_valid,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   output logic                      wb_wen,
   output logic [ADDR_W-1:0]         wb_adr,
   output logic [DATA_W-1:0]         wb_data,
   output logic [2**ADDR_W-1:0]      pend_mask,
   output logic [CNT_W-1:0]          conflict_cnt
);

   localparam int unsigned PtrW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [PtrW-1:0] LastIdx = PtrW'(NUM_REQ - 1);

   logic [PtrW-1:0]      rr_ptr;
   logic [PtrW-1:0]      gnt_idx;
   logic                 gnt_any;
   logic [ADDR_W-1:0]    sel_addr;
   logic [DATA_W-1:0]    sel_data;
   logic                 wr_en;
   logic                 multi_valid;
   logic [2**ADDR_W-1:0] pend_next;

   // Round-robin search from rr_ptr; reset masks the grant so nothing is accepted.
   always_comb begin
      int unsigned idx;
      gnt_any = 1'b0;
      gnt_idx = '0;
      idx     = 0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         idx = (32'(rr_ptr) + k) % NUM_REQ;
         if (!gnt_any && req_valid[idx]) begin
            gnt_any = 1'b1;
            gnt_idx = PtrW'(idx);
         end
      end
      if (reset) begin
         gnt_any = 1'b0;
      end
   end

   // One-hot ready for the granted requester; a grant implies a transfer this edge.
   always_comb begin
      req_ready = '0;
      if (gnt_any) begin
         req_ready[gnt_idx] = 1'b1;
      end
   end

   assign sel_addr = req_addr[gnt_idx*ADDR_W +: ADDR_W];
   assign sel_data = req_data[gnt_idx*DATA_W +: DATA_W];

   // x0 writes complete the handshake but never reach the port.
   assign wr_en = gnt_any && (sel_addr != '0);

   // Pending-write mask is one-hot at the address about to be written.
   always_comb begin
      pend_next = '0;
      if (wr_en) begin
         pend_next[sel_addr] = 1'b1;
      end
   end

   // Conflict detect: two or more requesters valid in the same cycle.
   always_comb begin
      int unsigned n;
      n = 0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         n = n + 32'(req_valid[k]);
      end
      multi_valid = (n >= 2);
   end

   // Pointer moves just past the last granted requester.
   always_ff @(posedge clock) begin
      if (reset) begin
         rr_ptr <= '0;
      end else if (gnt_any) begin
         rr_ptr <= (gnt_idx == LastIdx) ? '0 : gnt_idx + 1'b1;
      end
   end

   // Write-port register; address and data hold when nothing is written.
   always_ff @(posedge clock) begin
      if (reset) begin
         wb_wen    <= 1'b0;
         wb_adr    <= '0;
         wb_data   <= '0;
         pend_mask <= '0;
      end else begin
         wb_wen    <= wr_en;
         pend_mask <= pend_next;
         if (wr_en) begin
            wb_adr  <= sel_addr;
            wb_data <= sel_data;
         end
      end
   end

   // Saturating conflict counter.
   always_ff @(posedge clock) begin
      if (reset) begin
         conflict_cnt <= '0;
      end else if (multi_valid && (conflict_cnt != '1)) begin
         conflict_cnt <= conflict_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios followed by random traffic,
// all checked against a behavioural model of the write-back rules.
module tb_regfile_wb_arbiter;

   localparam int unsigned N  = 3;
   localparam int unsigned AW = 4;
   localparam int unsigned DW = 32;
   localparam int unsigned CW = 4;
   localparam int          CntMax = (1 << CW) - 1;

   logic                 clock = 1'b0;
   logic                 reset;
   logic [N-1:0]         req_valid;
   logic [N-1:0]         req_ready;
   logic [N*AW-1:0]      req_addr;
   logic [N*DW-1:0]      req_data;
   logic                 wb_wen;
   logic [AW-1:0]        wb_adr;
   logic [DW-1:0]        wb_data;
   logic [2**AW-1:0]     pend_mask;
   logic [CW-1:0]        conflict_cnt;

   regfile_wb_arbiter #(
      .NUM_REQ(N),
      .ADDR_W (AW),
      .DATA_W (DW),
      .CNT_W  (CW)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_addr    (req_addr),
      .req_data    (req_data),
      .wb_wen      (wb_wen),
      .wb_adr      (wb_adr),
      .wb_data     (wb_data),
      .pend_mask   (pend_mask),
      .conflict_cnt(conflict_cnt)
   );

   always #5 clock = ~clock;

   // Stimulus state per requester.
   bit            rst;
   bit            v[N];
   logic [AW-1:0] a[N];
   logic [DW-1:0] d[N];

   // Reference model state.
   int            m_ptr;
   bit            m_wen;
   logic [AW-1:0] m_adr;
   logic [DW-1:0] m_data;
   logic [15:0]   m_pend;
   int            m_cnt;

   int vectors = 0;
   int miscompares = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // First valid requester at or after the pointer, wrapping; none while in reset.
   function automatic int model_grant();
      if (rst) return -1;
      for (int k = 0; k < N; k++) begin
         int idx;
         idx = (m_ptr + k) % N;
         if (v[idx]) return idx;
      end
      return -1;
   endfunction

   // One cycle: drive, check ready, clock, update model, check registered outputs.
   // clr=1 drops a granted request; clr=0 re-issues the same request next cycle.
   task automatic step(input bit clr);
      int g;
      int nv;
      logic [N-1:0] er;
      @(negedge clock);
      reset = rst;
      for (int i = 0; i < N; i++) begin
         req_valid[i]           = v[i];
         req_addr[i*AW +: AW]   = a[i];
         req_data[i*DW +: DW]   = d[i];
      end
      #1;
      g  = model_grant();
      er = '0;
      if (g >= 0) er[g] = 1'b1;
      chk("ready", 64'(req_ready), 64'(er));
      nv = 0;
      for (int i = 0; i < N; i++) nv += int'(v[i]);
      @(posedge clock);
      if (rst) begin
         m_wen = 0; m_adr = '0; m_data = '0; m_pend = '0; m_cnt = 0; m_ptr = 0;
      end else begin
         if (nv >= 2 && m_cnt < CntMax) m_cnt++;
         m_wen  = 0;
         m_pend = '0;
         if (g >= 0) begin
            m_ptr = (g + 1) % N;
            if (a[g] != 0) begin
               m_wen  = 1;
               m_adr  = a[g];
               m_data = d[g];
               m_pend = 16'(1) << a[g];
            end
            if (clr) v[g] = 0;
         end
      end
      #1;
      chk("wb_wen", 64'(wb_wen), 64'(m_wen));
      chk("wb_adr", 64'(wb_adr), 64'(m_adr));
      chk("wb_data", 64'(wb_data), 64'(m_data));
      chk("pend_mask", 64'(pend_mask), 64'(m_pend));
      chk("conflict_cnt", 64'(conflict_cnt), 64'(m_cnt));
   endtask

   initial begin
      reset = 1'b1; req_valid = '0; req_addr = '0; req_data = '0;
      rst = 1;
      m_ptr = 0; m_wen = 0; m_adr = '0; m_data = '0; m_pend = '0; m_cnt = 0;
      for (int i = 0; i < N; i++) begin v[i] = 0; a[i] = '0; d[i] = '0; end

      // Reset state
      step(1);
      step(1);
      rst = 0;

      // Single requester 1, addr 5
      v[1] = 1; a[1] = 4'd5; d[1] = 32'hDEADBEEF;
      step(1);
      chk("t1_pend", 64'(pend_mask), 64'h0020);
      chk("t1_data", 64'(wb_data), 64'hDEADBEEF);

      // All three valid from reset: grants 0,1,2, counter 1,2,2
      rst = 1; step(1); rst = 0;
      for (int i = 0; i < N; i++) begin
         v[i] = 1; a[i] = AW'(i + 1); d[i] = 32'hA000_0000 + i;
      end
      step(1);
      chk("t2_g0", 64'(wb_adr), 64'd1);
      chk("t2_c1", 64'(conflict_cnt), 64'd1);
      step(1);
      chk("t2_g1", 64'(wb_adr), 64'd2);
      chk("t2_c2", 64'(conflict_cnt), 64'd2);
      step(1);
      chk("t2_g2", 64'(wb_adr), 64'd3);
      chk("t2_c3", 64'(conflict_cnt), 64'd2);

      // Requester 2 writes x0; pointer must come back to 0
      v[2] = 1; a[2] = '0; d[2] = 32'h1234;
      step(1);
      chk("t3_wen", 64'(wb_wen), 64'd0);
      chk("t3_pend", 64'(pend_mask), 64'd0);
      v[0] = 1; a[0] = 4'd8; d[0] = 32'h8;
      v[1] = 1; a[1] = 4'd9; d[1] = 32'h9;
      step(1);
      chk("t3_ptr0", 64'(wb_adr), 64'd8);
      step(1);

      // Reset with two requesters valid
      v[0] = 1; v[1] = 1; rst = 1;
      step(0);
      chk("t4_cnt", 64'(conflict_cnt), 64'd0);
      rst = 0;

      // Same address from requesters 0 and 1, serialised in grant order
      a[0] = 4'd7; d[0] = 32'h11; a[1] = 4'd7; d[1] = 32'h22;
      step(1);
      chk("t5_first", 64'(wb_data), 64'h11);
      step(1);
      chk("t5_second", 64'(wb_data), 64'h22);

      // Counter saturation with two requesters held
      v[0] = 1; v[1] = 1;
      for (int n = 0; n < 20; n++) step(0);
      chk("t6_sat", 64'(conflict_cnt), 64'(CntMax));
      v[0] = 0; v[1] = 0;
      step(1);

      // Random traffic; waiting requesters hold their request until granted
      for (int n = 0; n < 400; n++) begin
         rst = ($urandom_range(0, 39) == 0);
         for (int i = 0; i < N; i++) begin
            if (!v[i] && $urandom_range(0, 1) == 1) begin
               v[i] = 1;
               a[i] = AW'($urandom_range(0, (1 << AW) - 1));
               d[i] = $urandom;
            end
         end
         step(1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
